rv16_operand_issue: RTL and testbench
=====================================

Name: rv16_operand_issue

Overview:
- Register-file and operand-issue stage directly upstream of the 16-bit ripple adder unit (rv16_add_unit).
- Holds the 16-entry architectural register file and accepts decoded ADD/SUB/ADDI requests via valid/ready.
- Reads and bypasses operands, applies SUB inversion and carry-in, and presents registered rs1_add_in/rs2_add_in/rp_cin to the adder.
- Accepts the writeback of results back into the register file.

Parameters:
- DATA, 16, datapath width; matches adder width.
- NREG, 16, number of architectural registers; register 0 hardwired to zero.
- AW, 4, register address width; equals log2(NREG).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded request present
- in_ready  out  1  stage can accept request
- in_op  in  2  0=ADD, 1=SUB, 2=ADDI, 3=reserved (treated as ADD)
- in_rs1_addr  in  AW  source 1 index
- in_rs2_addr  in  AW  source 2 index (ignored for ADDI)
- in_rd_addr  in  AW  destination index, carried through
- in_imm  in  DATA  immediate for ADDI
- wb_en  in  1  writeback strobe
- wb_addr  in  AW  writeback index
- wb_data  in  DATA  writeback value
- rs1_add_in  out  DATA  adder operand A
- rs2_add_in  out  DATA  adder operand B (pre-inverted for SUB)
- rp_cin  out  1  adder carry-in
- out_valid  out  1  operands valid
- out_ready  in  1  downstream accepts
- out_rd_addr  out  AW  destination carried with operands

Behaviour:
- Reset (async, rst=1): all registers, including regfile entries, clear to 0. out_valid=0. rs1_add_in=0, rs2_add_in=0, rp_cin=0, out_rd_addr=0.
- Handshake:
  - in_ready = !out_valid || out_ready (single-entry pipeline register, combinational backpressure).
  - Transfer on in_valid && in_ready.
  - Output holds stable while out_valid && !out_ready.
- Latency: 1 cycle. Request accepted at edge N appears with out_valid=1 after edge N.
- State: out_valid flag, EMPTY/FULL.
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with out_ready.
  - FULL→EMPTY on out_ready without accept.
- Register file read is combinational. Register 0 always reads 0; writes to register 0 are discarded.
- Bypass: if wb_en && wb_addr==src && src!=0 in the accept cycle, wb_data is used instead of the array value. Applies independently to rs1 and rs2.
- Operand B selection:
  - ADD: rs2 value, cin=0.
  - SUB: bitwise ~rs2 value, cin=1.
  - ADDI: in_imm, cin=0.
  - Reserved op: as ADD.
- Writeback: on wb_en, regfile[wb_addr] <= wb_data at the edge. Writeback is independent of the handshake and never stalls.
- Simultaneous writeback and accept to the same address: the bypass provides the new value, and the array also updates.
- Reset mid-transfer: the pending output is dropped, out_valid=0 immediately.
- Operands are not re-read while held. A stall across a writeback keeps the value captured at accept.

Optional Feature:
- Macro: RV16_SCOREBOARD_EN.
- With the macro defined: an NREG-bit pending vector is set at the rd of each accepted request (rd!=0) and cleared on wb_en at wb_addr.
  - in_ready is additionally forced low while any used source is pending and not being bypassed this cycle.
  - Used sources: rs1 always; rs2 unless ADDI.
  - A set and a clear of the same bit in the same cycle results in set.
  - Reset clears the pending vector.
- Without the macro: no pending vector. Software or upstream logic guarantees that hazards are resolved.

Decomposition:
- Package rv16_pkg: op enum (OP_ADD, OP_SUB, OP_ADDI, OP_RSVD), DATA/AW/NREG constants, and a struct for the issued operand bundle.
- Sub-module rv16_regfile: 2 read ports, 1 write port, register 0 hardwired to zero, with bypass. It is instantiated once.
- Issue register, operand mux, and scoreboard stay in the top module.

Test Plan:
- Reset then write: wb r3=0x1234 and r4=0x0011, then ADD r3,r4 → next cycle rs1_add_in=0x1234, rs2_add_in=0x0011, rp_cin=0, out_valid=1.
- SUB: r3=0x1234, r4=0x0011, SUB → rs2_add_in=0xFFEE, rp_cin=1; the adder sum is 0x1223.
- Bypass and r0:
  - wb r5=0xBEEF in the same cycle as ADD r5,r0 → rs1_add_in=0xBEEF, rs2_add_in=0x0000.
  - wb r0=0xFFFF, then a read of r0 → 0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. When out_ready=1, the next request is accepted the same cycle, with no loss or duplication.
- ADDI and async reset:
  - ADDI r1, imm=0x8000 → rs2_add_in=0x8000.
  - rst asserted mid-FULL → out_valid=0 and outputs 0 without waiting for a clock edge.
- RV16_SCOREBOARD_EN: ADD rd=r6, then ADD using r6 → in_ready=0 until wb r6. In the wb cycle the bypass value is issued.

Source files
------------

// File: rtl/rv16_pkg.sv
// rv16_pkg -- shared types and sizes for the rv16 operand-issue slice.
//   DATA    : datapath width, matches rv16_add_unit
//   NREG/AW : architectural register count and index width
//   op_e    : decoded operation presented to the issue stage
//   issue_t : operand bundle held in the issue register
//   state_e : occupancy of the single-entry issue register
package rv16_pkg;
   localparam int DATA = 16;
   localparam int NREG = 16;
   localparam int AW   = 4;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_ADDI = 2'd2,
      OP_RSVD = 2'd3
   } op_e;

   typedef struct packed {
      logic [DATA-1:0] rs1;
      logic [DATA-1:0] rs2;
      logic            cin;
      logic [AW-1:0]   rd;
   } issue_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;
endpackage

// File: rtl/rv16_operand_issue_if.sv
// rv16_operand_issue_if -- request, writeback and adder-operand bundle.
//   master : upstream decode / writeback source / adder side (drives requests)
//   slave  : the operand-issue stage
//   in_*   : decoded request with valid/ready
//   wb_*   : result writeback into the register file
//   rs1_add_in/rs2_add_in/rp_cin/out_* : registered operands to the adder
interface rv16_operand_issue_if;
   import rv16_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_op;
   logic [AW-1:0]   in_rs1_addr;
   logic [AW-1:0]   in_rs2_addr;
   logic [AW-1:0]   in_rd_addr;
   logic [DATA-1:0] in_imm;
   logic            wb_en;
   logic [AW-1:0]   wb_addr;
   logic [DATA-1:0] wb_data;
   logic [DATA-1:0] rs1_add_in;
   logic [DATA-1:0] rs2_add_in;
   logic            rp_cin;
   logic            out_valid;
   logic            out_ready;
   logic [AW-1:0]   out_rd_addr;

   modport master (
      output in_valid, in_op, in_rs1_addr, in_rs2_addr, in_rd_addr, in_imm,
      output wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, rs1_add_in, rs2_add_in, rp_cin, out_valid, out_rd_addr
   );

   modport slave (
      input  in_valid, in_op, in_rs1_addr, in_rs2_addr, in_rd_addr, in_imm,
      input  wb_en, wb_addr, wb_data, out_ready,
      output in_ready, rs1_add_in, rs2_add_in, rp_cin, out_valid, out_rd_addr
   );
endinterface

// File: rtl/rv16_regfile.sv
// rv16_regfile -- 16x16 architectural register file, 2 read / 1 write.
//   clk_i, rst_i        : clock, async active-high reset (clears all entries)
//   raddr1_i/raddr2_i   : combinational read indices
//   we_i/waddr_i/wdata_i: write port, takes effect at the clock edge
//   rdata1_o/rdata2_o   : read data, with same-cycle write bypass
// Register 0 reads as zero and ignores writes.
module rv16_regfile
   import rv16_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [AW-1:0]   raddr1_i,
   input  logic [AW-1:0]   raddr2_i,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [DATA-1:0] wdata_i,
   output logic [DATA-1:0] rdata1_o,
   output logic [DATA-1:0] rdata2_o
);
   logic [DATA-1:0] regs_q [NREG];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (we_i && waddr_i != '0) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata1_o = regs_q[raddr1_i];
      if (raddr1_i == '0)                      rdata1_o = '0;
      else if (we_i && waddr_i == raddr1_i)    rdata1_o = wdata_i;
   end

   always_comb begin
      rdata2_o = regs_q[raddr2_i];
      if (raddr2_i == '0)                      rdata2_o = '0;
      else if (we_i && waddr_i == raddr2_i)    rdata2_o = wdata_i;
   end
endmodule

// File: rtl/rv16_operand_issue.sv
// rv16_operand_issue -- register file plus operand-issue register feeding
// rv16_add_unit.
//   clk, rst : clock, async active-high reset
//   bus      : rv16_operand_issue_if.slave (request in, writeback in,
//              registered adder operands out)
// Optional: RV16_SCOREBOARD_EN adds a pending-destination vector that
// holds off requests whose sources are still in flight.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | issue register empty, out_valid=0
// ST_FULL  | operands held for the adder, out_valid=1
module rv16_operand_issue
   import rv16_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   rv16_operand_issue_if.slave  bus
);
   state_e          state_q;
   issue_t          issue_q;
   issue_t          issue_d;
   logic [DATA-1:0] rs1_val;
   logic [DATA-1:0] rs2_val;
   logic            hazard;
   logic            accept;

   rv16_regfile u_regfile (
      .clk_i    (clk),
      .rst_i    (rst),
      .raddr1_i (bus.in_rs1_addr),
      .raddr2_i (bus.in_rs2_addr),
      .we_i     (bus.wb_en),
      .waddr_i  (bus.wb_addr),
      .wdata_i  (bus.wb_data),
      .rdata1_o (rs1_val),
      .rdata2_o (rs2_val)
   );

   assign bus.in_ready = (state_q == ST_EMPTY || bus.out_ready) && !hazard;
   assign accept       = bus.in_valid && bus.in_ready;

   // SUB is issued as a + ~b + 1 so the adder never needs to know the op.
   always_comb begin
      issue_d.rs1 = rs1_val;
      issue_d.rd  = bus.in_rd_addr;
      issue_d.rs2 = rs2_val;
      issue_d.cin = 1'b0;
      case (op_e'(bus.in_op))
         OP_SUB: begin
            issue_d.rs2 = ~rs2_val;
            issue_d.cin = 1'b1;
         end
         OP_ADDI: issue_d.rs2 = bus.in_imm;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         issue_q <= '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_q <= ST_FULL;
                  issue_q <= issue_d;
               end
            end
            ST_FULL: begin
               if (accept)             issue_q <= issue_d;
               else if (bus.out_ready) state_q <= ST_EMPTY;
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   assign bus.out_valid   = (state_q == ST_FULL);
   assign bus.rs1_add_in  = issue_q.rs1;
   assign bus.rs2_add_in  = issue_q.rs2;
   assign bus.rp_cin      = issue_q.cin;
   assign bus.out_rd_addr = issue_q.rd;

`ifdef RV16_SCOREBOARD_EN
   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_set;
   logic [NREG-1:0] pend_clr;
   logic            uses_rs2;
   logic            rs1_byp;
   logic            rs2_byp;

   assign uses_rs2 = (op_e'(bus.in_op) != OP_ADDI);
   assign rs1_byp  = bus.wb_en && bus.wb_addr == bus.in_rs1_addr;
   assign rs2_byp  = bus.wb_en && bus.wb_addr == bus.in_rs2_addr;
   assign hazard   = (pend_q[bus.in_rs1_addr] && !rs1_byp) ||
                     (uses_rs2 && pend_q[bus.in_rs2_addr] && !rs2_byp);

   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (accept && bus.in_rd_addr != '0) pend_set[bus.in_rd_addr] = 1'b1;
      if (bus.wb_en)                       pend_clr[bus.wb_addr]    = 1'b1;
   end

   // Set wins over clear: a new producer of rd is issuing this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= (pend_q & ~pend_clr) | pend_set;
   end
`else
   assign hazard = 1'b0;
`endif
endmodule

// File: tb/tb_rv16_operand_issue.sv
module tb_rv16_operand_issue;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   rv16_operand_issue_if bus ();

   rv16_operand_issue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [3:0]  rd;
      logic [15:0] imm;
      logic        wb_en;
      logic [3:0]  wb_addr;
      logic [15:0] wb_data;
      logic [15:0] e_rs1;
      logic [15:0] e_rs2;
      logic        e_cin;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid    = 1'b0;
      bus.in_op       = 2'd0;
      bus.in_rs1_addr = '0;
      bus.in_rs2_addr = '0;
      bus.in_rd_addr  = '0;
      bus.in_imm      = '0;
      bus.wb_en       = 1'b0;
      bus.wb_addr     = '0;
      bus.wb_data     = '0;
      bus.out_ready   = 1'b1;
   endtask

   task automatic req(input logic [1:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic [3:0] rd, input logic [15:0] imm);
      bus.in_valid    = 1'b1;
      bus.in_op       = op;
      bus.in_rs1_addr = rs1;
      bus.in_rs2_addr = rs2;
      bus.in_rd_addr  = rd;
      bus.in_imm      = imm;
   endtask

   task automatic wb(input logic [3:0] a, input logic [15:0] d);
      bus.wb_en   = 1'b1;
      bus.wb_addr = a;
      bus.wb_data = d;
      step();
      bus.wb_en   = 1'b0;
   endtask

   logic [15:0] sum;

   initial begin
      checks   = 0;
      failures = 0;
      //          op    rs1 rs2 rd  imm       wb    wba wbd       e_rs1     e_rs2     cin
      vecs[0] = '{2'd0, 3,  4,  7,  16'h0000, 1'b0, 0,  16'h0000, 16'h1234, 16'h0011, 1'b0};
      vecs[1] = '{2'd1, 3,  4,  8,  16'h0000, 1'b0, 0,  16'h0000, 16'h1234, 16'hFFEE, 1'b1};
      vecs[2] = '{2'd0, 5,  0,  9,  16'h0000, 1'b1, 5,  16'hBEEF, 16'hBEEF, 16'h0000, 1'b0};
      vecs[3] = '{2'd0, 5,  5,  10, 16'h0000, 1'b0, 0,  16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
      vecs[4] = '{2'd0, 0,  0,  11, 16'h0000, 1'b1, 0,  16'hFFFF, 16'h0000, 16'h0000, 1'b0};
      vecs[5] = '{2'd0, 0,  0,  12, 16'h0000, 1'b0, 0,  16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[6] = '{2'd2, 3,  4,  13, 16'h8000, 1'b0, 0,  16'h0000, 16'h1234, 16'h8000, 1'b0};
      vecs[7] = '{2'd3, 3,  4,  14, 16'h0000, 1'b0, 0,  16'h0000, 16'h1234, 16'h0011, 1'b0};
      vecs[8] = '{2'd1, 4,  4,  15, 16'h0000, 1'b1, 4,  16'h00F0, 16'h00F0, 16'hFF0F, 1'b1};
      vecs[9] = '{2'd1, 0,  3,  1,  16'h0000, 1'b0, 0,  16'h0000, 16'h0000, 16'hEDCB, 1'b1};

      idle();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_rs1", bus.rs1_add_in, 0);
      chk("rst_rs2", bus.rs2_add_in, 0);
      chk("rst_cin", bus.rp_cin, 0);
      chk("rst_rd", bus.out_rd_addr, 0);
      step();
      rst = 1'b0;
      step();
      chk("rst_in_ready", bus.in_ready, 1);

      wb(4'd3, 16'h1234);
      wb(4'd4, 16'h0011);

      for (int i = 0; i < 10; i++) begin
         req(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm);
         bus.wb_en   = vecs[i].wb_en;
         bus.wb_addr = vecs[i].wb_addr;
         bus.wb_data = vecs[i].wb_data;
         bus.out_ready = 1'b1;
         step();
         bus.wb_en = 1'b0;
         chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
         chk($sformatf("v%0d_rs1", i), bus.rs1_add_in, vecs[i].e_rs1);
         chk($sformatf("v%0d_rs2", i), bus.rs2_add_in, vecs[i].e_rs2);
         chk($sformatf("v%0d_cin", i), bus.rp_cin, vecs[i].e_cin);
         chk($sformatf("v%0d_rd", i), bus.out_rd_addr, vecs[i].rd);
         if (i == 1) begin
            sum = bus.rs1_add_in + bus.rs2_add_in + {15'd0, bus.rp_cin};
            chk("sub_sum", sum, 16'h1223);
         end
      end
      bus.in_valid = 1'b0;
      step();
      chk("drain_valid", bus.out_valid, 0);

      // Backpressure: hold for 3 cycles, writeback to a held source meanwhile.
      req(2'd0, 4'd3, 4'd4, 4'd2, 16'h0);
      step();
      chk("bp_first_rs2", bus.rs2_add_in, 16'h00F0);
      req(2'd1, 4'd5, 4'd3, 4'd11, 16'h0);
      bus.out_ready = 1'b0;
      bus.wb_en   = 1'b1;
      bus.wb_addr = 4'd3;
      bus.wb_data = 16'h5555;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d_in_ready", k), bus.in_ready, 0);
         step();
         bus.wb_en = 1'b0;
         chk($sformatf("bp%0d_valid", k), bus.out_valid, 1);
         chk($sformatf("bp%0d_rs1", k), bus.rs1_add_in, 16'h1234);
         chk($sformatf("bp%0d_rs2", k), bus.rs2_add_in, 16'h00F0);
         chk($sformatf("bp%0d_rd", k), bus.out_rd_addr, 2);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", bus.in_ready, 1);
      step();
      chk("bp_next_rs1", bus.rs1_add_in, 16'hBEEF);
      chk("bp_next_rs2", bus.rs2_add_in, 16'hAAAA);
      chk("bp_next_cin", bus.rp_cin, 1);
      chk("bp_next_rd", bus.out_rd_addr, 11);
      chk("bp_next_valid", bus.out_valid, 1);
      bus.in_valid = 1'b0;
      step();
      chk("bp_no_dup", bus.out_valid, 0);

      // Async reset while FULL and stalled.
      req(2'd0, 4'd3, 4'd4, 4'd12, 16'h0);
      bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      chk("ar_full_valid", bus.out_valid, 1);
      chk("ar_full_rs1", bus.rs1_add_in, 16'h5555);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", bus.out_valid, 0);
      chk("ar_rs1", bus.rs1_add_in, 0);
      chk("ar_rs2", bus.rs2_add_in, 0);
      chk("ar_rd", bus.out_rd_addr, 0);
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      req(2'd0, 4'd3, 4'd4, 4'd13, 16'h0);
      step();
      chk("ar_rf_rs1", bus.rs1_add_in, 0);
      chk("ar_rf_rs2", bus.rs2_add_in, 0);
      bus.in_valid = 1'b0;
      step();

`ifdef RV16_SCOREBOARD_EN
      req(2'd0, 4'd1, 4'd2, 4'd6, 16'h0);
      step();
      req(2'd0, 4'd6, 4'd0, 4'd7, 16'h0);
      #1;
      chk("sb_stall_ready", bus.in_ready, 0);
      step();
      chk("sb_stall_valid", bus.out_valid, 0);
      bus.wb_en   = 1'b1;
      bus.wb_addr = 4'd6;
      bus.wb_data = 16'h0ABC;
      #1;
      chk("sb_wb_ready", bus.in_ready, 1);
      step();
      bus.wb_en = 1'b0;
      bus.in_valid = 1'b0;
      chk("sb_issue_valid", bus.out_valid, 1);
      chk("sb_issue_rs1", bus.rs1_add_in, 16'h0ABC);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
